// File: rtl/uop_issue_buffer_pkg.sv
// Shared issue-buffer constants and the instruction entry layout carried between
// the micro-op sequencer and the issue stage.
package uop_issue_buffer_pkg;

  localparam int IBUF_DEPTH = 4;
  localparam int IBUF_CNT_W = $clog2(IBUF_DEPTH + 1);
  localparam int IBUF_DATAW = 128;

  typedef struct packed {
    logic [31:0] uuid;
    logic [3:0]  tmask;
    logic [31:0] pc;
    logic [2:0]  ex_type;
    logic [4:0]  op_type;
    logic        wb;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [30:0] imm;
  } ibuf_data_t;

endpackage

// File: rtl/uop_ibuf_fifo.sv
// Single-warp instruction FIFO; head is valid the cycle after a push.
// Caller must not push when full or pop when empty.
module uop_ibuf_fifo
  import uop_issue_buffer_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int DATAW = IBUF_DATAW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [DATAW-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [DATAW-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + PTR_W'(1);
    if (pop_i)  rd_d = rd_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the counters.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/uop_issue_buffer.sv
// Per-warp instruction buffer with round-robin issue; 1-cycle latency, or 0 when idle
// with IBUF_BYPASS_EN. in_ready depends only on registered fill state; a stalled grant is held.
module uop_issue_buffer
  import uop_issue_buffer_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = IBUF_DEPTH,
  parameter int DATAW     = IBUF_DATAW,
  localparam int WIS_W    = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIS_W-1:0]     in_wis,
  input  logic [DATAW-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIS_W-1:0]     out_wis,
  output logic [DATAW-1:0]     out_data,
  input  logic                 out_ready,
  output logic [NUM_WARPS-1:0] empty_mask
);

  logic [NUM_WARPS-1:0] full_vec, empty_vec, push_vec, pop_vec;
  logic [DATAW-1:0]     head [NUM_WARPS];

  logic [WIS_W-1:0] rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [WIS_W-1:0] lock_wis_q, lock_wis_d;

  logic             arb_vld;
  logic [WIS_W-1:0] arb_wis, gnt_wis;
  logic             byp, push_fire, pop_fire;
  int               idx;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_fifo
    uop_ibuf_fifo #(
      .DEPTH (DEPTH),
      .DATAW (DATAW)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push_vec[w]),
      .push_data_i (in_data),
      .pop_i       (pop_vec[w]),
      .full_o      (full_vec[w]),
      .empty_o     (empty_vec[w]),
      .head_o      (head[w])
    );
  end

  assign in_ready   = ~full_vec[in_wis];
  assign empty_mask = empty_vec;

`ifdef IBUF_BYPASS_EN
  assign byp = in_valid && (&empty_vec);
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    arb_vld = 1'b0;
    arb_wis = '0;
    idx     = 0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = (int'(rr_q) + i) % NUM_WARPS;
      if (!arb_vld && !empty_vec[idx]) begin
        arb_vld = 1'b1;
        arb_wis = WIS_W'(idx);
      end
    end
  end

  // A stalled grant stays locked so out_wis/out_data cannot shift under the consumer.
  assign gnt_wis   = lock_q ? lock_wis_q : arb_wis;
  assign out_valid = arb_vld | byp;
  assign out_wis   = byp ? in_wis : gnt_wis;
  assign out_data  = byp ? in_data : (arb_vld ? head[gnt_wis] : '0);

  assign push_fire = in_valid && in_ready && !(byp && out_ready);
  assign pop_fire  = out_valid && out_ready && !byp;

  always_comb begin
    push_vec   = '0;
    pop_vec    = '0;
    rr_d       = rr_q;
    lock_d     = out_valid && !out_ready;
    lock_wis_d = out_wis;
    for (int w = 0; w < NUM_WARPS; w++) begin
      push_vec[w] = push_fire && (in_wis == WIS_W'(w));
      pop_vec[w]  = pop_fire && (gnt_wis == WIS_W'(w));
    end
    if (out_valid && out_ready) begin
      rr_d = (out_wis == WIS_W'(NUM_WARPS - 1)) ? '0 : out_wis + WIS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_wis_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_wis_q <= lock_wis_d;
    end
  end

endmodule

// File: tb/tb_uop_issue_buffer.sv
// Scoreboard bench for uop_issue_buffer: per-warp expected queues filled on push,
// drained and compared on every output handshake.
module tb_uop_issue_buffer;

  localparam int NW  = 4;
  localparam int DEP = 4;
  localparam int DW  = 128;
`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    in_wis, out_wis;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] empty_mask;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] sbq [NW][$];
  logic [1:0]    wis_log[$];

  always #5 clk = ~clk;

  uop_issue_buffer #(
    .NUM_WARPS (NW),
    .DEPTH     (DEP),
    .DATAW     (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_wis     (in_wis),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_wis    (out_wis),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .empty_mask (empty_mask)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NW-1:0] model_mask();
    logic [NW-1:0] m;
    for (int w = 0; w < NW; w++) m[w] = (sbq[w].size() == 0);
    return m;
  endfunction

  // Inputs are driven at posedge+1; checks land at posedge+2.
  task automatic tick();
    logic [DW-1:0] d;
    logic [NW-1:0] m;
    #1;
    if (reset) begin
      for (int w = 0; w < NW; w++) sbq[w].delete();
      wis_log.delete();
    end else begin
      m = model_mask();
      check("empty_mask", empty_mask, m);
      check("in_ready", in_ready, sbq[in_wis].size() < DEP);
      check("out_valid", out_valid, (m != '1) || (BYP && in_valid && (m == '1)));
      if (in_valid && in_ready) sbq[in_wis].push_back(in_data);
      if (out_valid && out_ready) begin
        wis_log.push_back(out_wis);
        check("pop_has_entry", sbq[out_wis].size() != 0, 1'b1);
        if (sbq[out_wis].size() != 0) begin
          d = sbq[out_wis].pop_front();
          check("out_data", out_data, d);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_wis   = w;
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    int i;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    i = 0;
    while (i < 40 && !(model_mask() == '1 && !out_valid)) begin
      tick();
      i++;
    end
    check("drain_empty_mask", empty_mask, 4'hf);
    check("drain_out_valid", out_valid, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_seq [6];
    logic [DW-1:0] held;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_wis    = '0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_empty_mask", empty_mask, 4'hf);

    // Fill warp 2, confirm it refuses a fifth push, then drain one per cycle.
    push_n(2'd2, 4);
    in_wis = 2'd2;
    #1;
    check("full_in_ready", in_ready, 1'b0);
    check("full_empty_mask", empty_mask, 4'b1011);
    push_n(2'd2, 1);
    wis_log.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("fill_pop_count", wis_log.size(), 4);
    for (int i = 0; i < wis_log.size(); i++) check("fill_pop_wis", wis_log[i], 2'd2);
    check("fill_drained", empty_mask, 4'hf);
    drain();

    // Round-robin across warps 0, 1, 3.
    do_reset();
    push_n(2'd0, 2);
    push_n(2'd1, 2);
    push_n(2'd3, 2);
    wis_log.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    exp_seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    check("rr_count", wis_log.size(), 6);
    for (int i = 0; i < 6 && i < wis_log.size(); i++) check("rr_wis", wis_log[i], exp_seq[i]);
    drain();

    // Stalled grant on warp 1 must not move when warp 0 fills behind it.
    do_reset();
    push_n(2'd1, 1);
    tick();
    held = sbq[1][0];
    for (int i = 0; i < 5; i++) begin
      check("stall_wis", out_wis, 2'd1);
      check("stall_data", out_data, held);
      if (i == 0) push_n(2'd0, 1);
      else tick();
    end
    wis_log.delete();
    drain();
    check("stall_first_pop", wis_log.size() > 0 ? wis_log[0] : 2'd3, 2'd1);

    // Concurrent push/pop on warp 0 across pointer wrap.
    do_reset();
    push_n(2'd0, 3);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_wis    = 2'd0;
    for (int i = 0; i < 10; i++) begin
      in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    in_valid = 1'b0;
    wis_log.delete();
    for (int i = 0; i < 3; i++) tick();
    check("pp_remaining", wis_log.size(), 3);
    check("pp_out_valid", out_valid, 1'b0);
    check("pp_empty_mask", empty_mask, 4'hf);

    // Reset with entries spread across warps.
    do_reset();
    push_n(2'd0, 2);
    push_n(2'd1, 2);
    push_n(2'd2, 2);
    check("pre_reset_mask", empty_mask, 4'b1000);
    do_reset();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_empty_mask", empty_mask, 4'hf);
    check("midrst_in_ready", in_ready, 1'b1);

    // Idle-path latency.
    in_valid  = 1'b1;
    in_wis    = 2'd3;
    in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
    out_ready = 1'b1;
    #1;
    check("idle_same_cycle_valid", out_valid, BYP);
    tick();
    in_valid = 1'b0;
    check("idle_next_mask", empty_mask, BYP ? 4'hf : 4'b0111);
    check("idle_next_valid", out_valid, !BYP);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
